timekeeper: RTL



---
 rtl/timekeeper_if.sv | 22 ++
 rtl/timekeeper.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/timekeeper_if.sv
// Bus between the time-of-day core and its consumers: tick, mode and keys in,
// BCD time and day rollover out.
interface timekeeper_if;
    logic       Sec_EN;
    logic [5:0] Mode;
    logic       AddHKey;
    logic       AddLKey;
    logic [7:0] Hour;
    logic [7:0] Minute;
    logic [7:0] Second;
    logic       DayCarry;

    modport master (
        output Sec_EN, Mode, AddHKey, AddLKey,
        input  Hour, Minute, Second, DayCarry
    );

    modport slave (
        input  Sec_EN, Mode, AddHKey, AddLKey,
        output Hour, Minute, Second, DayCarry
    );
endinterface

// File: rtl/timekeeper.sv
// BCD 24-hour time-of-day core with two debounced, active-low set keys.
// Define TIMEKEEPER_KEY_REPEAT_EN to build in the held-key auto-repeat.
module timekeeper #(
    parameter int DEB_CYCLES   = 20,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic         CP,
    input  logic         nCR,
    timekeeper_if.slave  tk
);

    localparam int              DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES);

`ifdef TIMEKEEPER_KEY_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_REPEAT} key_state_e;
`else
    typedef enum logic {ST_IDLE, ST_PRESSED} key_state_e;
`endif

    // Index 0 is the minute key, index 1 the hour key.
    logic [1:0] key_raw;
    logic [1:0] key_stb;

    assign key_raw = {tk.AddHKey, tk.AddLKey};

    for (genvar k = 0; k < 2; k++) begin : g_key
        logic             sync1_q;
        logic             sync2_q;
        key_state_e       state_q;
        logic [DEB_W-1:0] deb_cnt_q;
        logic             stb_q;
`ifdef TIMEKEEPER_KEY_REPEAT_EN
        logic [REP_W-1:0] rep_cnt_q;
`endif

        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge values of its neighbours.
        always_ff @(posedge CP or negedge nCR) begin
            if (!nCR) begin
                sync1_q   <= 1'b1;
                sync2_q   <= 1'b1;
                state_q   <= ST_IDLE;
                deb_cnt_q <= '0;
                stb_q     <= 1'b0;
`ifdef TIMEKEEPER_KEY_REPEAT_EN
                rep_cnt_q <= '0;
`endif
            end else begin
                sync1_q <= key_raw[k];
                sync2_q <= sync1_q;
                stb_q   <= 1'b0;

                case (state_q)
                    ST_IDLE: begin
                        if (deb_cnt_q == DEB_MAX) begin
                            stb_q     <= 1'b1;
                            state_q   <= ST_PRESSED;
                            deb_cnt_q <= '0;
`ifdef TIMEKEEPER_KEY_REPEAT_EN
                            rep_cnt_q <= '0;
`endif
                        end else if (!sync2_q) begin
                            deb_cnt_q <= deb_cnt_q + DEB_W'(1);
                        end else begin
                            deb_cnt_q <= '0;
                        end
                    end

                    default: begin
                        // Held states count consecutive released samples.
                        if (deb_cnt_q == DEB_MAX) begin
                            state_q   <= ST_IDLE;
                            deb_cnt_q <= '0;
                        end else if (sync2_q) begin
                            deb_cnt_q <= deb_cnt_q + DEB_W'(1);
                        end else begin
                            deb_cnt_q <= '0;
`ifdef TIMEKEEPER_KEY_REPEAT_EN
                            if (state_q == ST_PRESSED) begin
                                if (rep_cnt_q == REP_W'(REPEAT_DELAY - 1)) begin
                                    stb_q     <= 1'b1;
                                    state_q   <= ST_REPEAT;
                                    rep_cnt_q <= '0;
                                end else begin
                                    rep_cnt_q <= rep_cnt_q + REP_W'(1);
                                end
                            end else begin
                                if (rep_cnt_q == REP_W'(REPEAT_RATE - 1)) begin
                                    stb_q     <= 1'b1;
                                    rep_cnt_q <= '0;
                                end else begin
                                    rep_cnt_q <= rep_cnt_q + REP_W'(1);
                                end
                            end
`endif
                        end
                    end
                endcase
            end
        end

        assign key_stb[k] = stb_q;
    end

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        if (v == max_v)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic       set_mode;
    logic [7:0] hour_q;
    logic [7:0] min_q;
    logic [7:0] sec_q;
    logic       day_carry_q;

    assign set_mode = (tk.Mode == 6'd1);

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            hour_q      <= 8'h00;
            min_q       <= 8'h00;
            sec_q       <= 8'h00;
            day_carry_q <= 1'b0;
        end else begin
            day_carry_q <= 1'b0;
            if (set_mode) begin
                // Minute and hour wrap independently here; no carry between them.
                sec_q <= 8'h00;
                if (key_stb[0])
                    min_q <= bcd_inc(min_q, 8'h59);
                if (key_stb[1])
                    hour_q <= bcd_inc(hour_q, 8'h23);
            end else if (tk.Sec_EN) begin
                sec_q <= bcd_inc(sec_q, 8'h59);
                if (sec_q == 8'h59) begin
                    min_q <= bcd_inc(min_q, 8'h59);
                    if (min_q == 8'h59) begin
                        hour_q <= bcd_inc(hour_q, 8'h23);
                        if (hour_q == 8'h23)
                            day_carry_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign tk.Hour     = hour_q;
    assign tk.Minute   = min_q;
    assign tk.Second   = sec_q;
    assign tk.DayCarry = day_carry_q;

endmodule
